// File: rtl/reg_issue_sequencer_if.sv
// ============================================================================
// Module      : reg_issue_sequencer_if
// Description : Instruction handshake, register-file and load-memory bundle
//               for reg_issue_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_issue_sequencer_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] readdata1;
  logic [7:0] readdata2;
  logic [1:0] read_register1;
  logic [1:0] read_register2;
  logic [1:0] destination_register;
  logic       regdst;
  logic       regwrite;
  logic [7:0] regwritedata;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic       err;

  // Sequencer side: masters the register file and the load memory.
  modport master (
    input  instr, instr_valid, readdata1, readdata2, mem_ack, mem_rdata,
    output instr_ready, read_register1, read_register2, destination_register,
           regdst, regwrite, regwritedata, mem_req, mem_addr, busy, done, err
  );

  modport slave (
    output instr, instr_valid, readdata1, readdata2, mem_ack, mem_rdata,
    input  instr_ready, read_register1, read_register2, destination_register,
           regdst, regwrite, regwritedata, mem_req, mem_addr, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/reg_issue_sequencer.sv
// ============================================================================
// Module      : reg_issue_sequencer
// Description : Multi-cycle ADD/ADDI/LW/NOP sequencer issuing one write-back
//               to a 4x8 register file. Optional macro SEQ_OVERFLOW_FLAG_EN
//               adds the sticky signed-overflow output ovf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_issue_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  wire                    CLK,
  input  wire                    RESET,
  reg_issue_sequencer_if.master  bus
`ifdef SEQ_OVERFLOW_FLAG_EN
  ,
  output logic                   ovf
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_LOAD   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] c_OP_ADD  = 2'b00;
  localparam logic [1:0] c_OP_LW   = 2'b10;
  localparam logic [1:0] c_OP_NOP  = 2'b11;
  localparam logic [3:0] c_TMO     = MEM_TIMEOUT[3:0];

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_instr;
  logic [7:0] r_rd1;
  logic [7:0] r_rd2;
  logic [7:0] r_res;
  logic [7:0] r_mem_addr;
  logic       r_regdst;
  logic [3:0] r_tmo;

  logic [1:0] w_op;
  logic [7:0] w_imm_sext;
  logic [7:0] w_opb;
  logic [7:0] w_sum;
  logic       w_tmo_hit;
  logic       w_instr_ready;
  logic       w_regwrite;
  logic       w_mem_req;
  logic       w_done;
  logic       w_err;

  // One adder serves ADD, ADDI and the LW address computation.
  assign w_op       = r_instr[7:6];
  assign w_imm_sext = {{6{r_instr[1]}}, r_instr[1:0]};
  assign w_opb      = (w_op == c_OP_ADD) ? r_rd2 : w_imm_sext;
  assign w_sum      = r_rd1 + w_opb;
  assign w_tmo_hit  = (r_tmo == c_TMO);

  always_comb begin
    w_next        = r_state;
    w_instr_ready = 1'b0;
    w_regwrite    = 1'b0;
    w_mem_req     = 1'b0;
    w_done        = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_instr_ready = 1'b1;
        if (bus.instr_valid) w_next = S_DECODE;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_op == c_OP_NOP) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (w_op == c_OP_LW) begin
          w_next = S_LOAD;
        end else begin
          w_next = S_WB;
        end
      end
      S_LOAD: begin
        w_mem_req = 1'b1;
        // An ack arriving with the expiring count still wins.
        if (bus.mem_ack) begin
          w_next = S_WB;
        end else if (w_tmo_hit) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_WB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_instr    <= 8'h00;
      r_rd1      <= 8'h00;
      r_rd2      <= 8'h00;
      r_res      <= 8'h00;
      r_mem_addr <= 8'h00;
      r_regdst   <= 1'b0;
      r_tmo      <= 4'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid) r_instr <= bus.instr;
        end
        S_DECODE: begin
          r_rd1 <= bus.readdata1;
          r_rd2 <= bus.readdata2;
        end
        S_EXEC: begin
          if (w_op == c_OP_LW) begin
            r_mem_addr <= w_sum;
            r_tmo      <= 4'd1;
          end else if (w_op != c_OP_NOP) begin
            r_res    <= w_sum;
            r_regdst <= (w_op == c_OP_ADD);
          end
        end
        S_LOAD: begin
          if (bus.mem_ack) begin
            r_res    <= bus.mem_rdata;
            r_regdst <= 1'b0;
          end else if (!w_tmo_hit) begin
            r_tmo <= r_tmo + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_OVERFLOW_FLAG_EN
  // Loaded on the EXEC->WB edge of ADD/ADDI so it is valid alongside the write.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf <= 1'b0;
    end else if (r_state == S_EXEC && w_op != c_OP_LW && w_op != c_OP_NOP) begin
      ovf <= (r_rd1[7] == w_opb[7]) && (w_sum[7] != r_rd1[7]);
    end
  end
`endif

  assign bus.instr_ready          = w_instr_ready;
  assign bus.read_register1       = r_instr[5:4];
  assign bus.read_register2       = r_instr[3:2];
  assign bus.destination_register = r_instr[1:0];
  assign bus.regdst               = r_regdst;
  assign bus.regwrite             = w_regwrite;
  assign bus.regwritedata         = r_res;
  assign bus.mem_req              = w_mem_req;
  assign bus.mem_addr             = r_mem_addr;
  assign bus.busy                 = (r_state != S_IDLE);
  assign bus.done                 = w_done;
  assign bus.err                  = w_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_issue_sequencer.sv
// ============================================================================
// Module      : tb_reg_issue_sequencer
// Description : Directed self-checking bench for reg_issue_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_issue_sequencer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
`ifdef SEQ_OVERFLOW_FLAG_EN
  logic ovf;
`endif

  reg_issue_sequencer_if bus ();

  reg_issue_sequencer #(.MEM_TIMEOUT(15)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
`ifdef SEQ_OVERFLOW_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one instruction and steps to the EXEC cycle.
  task automatic issue(input logic [7:0] ins, input logic [7:0] d1, input logic [7:0] d2);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    bus.instr       = 8'hFF;
    bus.readdata1   = d1;
    bus.readdata2   = d2;
    tick();
  endtask

  initial begin
    logic bad;
    n_tests = 0;
    n_fail  = 0;
    bus.instr       = 8'h00;
    bus.instr_valid = 1'b0;
    bus.readdata1   = 8'h00;
    bus.readdata2   = 8'h00;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 8'h00;
    rst = 1'b1;
    #12;
    check("rst_ready", bus.instr_ready, 1);
    check("rst_outs", {bus.busy, bus.regwrite, bus.mem_req, bus.done, bus.err, bus.regdst}, 0);
    check("rst_regs", {bus.read_register1, bus.read_register2, bus.destination_register}, 0);
    check("rst_data", {bus.regwritedata, bus.mem_addr}, 0);
`ifdef SEQ_OVERFLOW_FLAG_EN
    check("rst_ovf", ovf, 0);
`endif
    tick();
    rst = 1'b0;

    // ADD 0x1B: r1 + r2 -> r3
    issue(8'h1B, 8'h05, 8'h07);
    check("add_rr", {bus.read_register1, bus.read_register2}, {2'd1, 2'd2});
    check("add_exec", {bus.busy, bus.instr_ready, bus.regwrite}, 3'b100);
    tick();
    check("add_wb", {bus.regwrite, bus.regdst, bus.done}, 3'b111);
    check("add_dest", bus.destination_register, 3);
    check("add_data", bus.regwritedata, 8'h0C);
    tick();
    check("add_retire", {bus.regwrite, bus.done, bus.instr_ready, bus.busy}, 4'b0010);

    // ADDI 0x47: r0 + (-1) -> rt=1
    issue(8'h47, 8'h00, 8'h99);
    check("addi_rr2", bus.read_register2, 1);
    tick();
    check("addi_wb", {bus.regwrite, bus.regdst}, 2'b10);
    check("addi_data", bus.regwritedata, 8'hFF);
    tick();

    // ADDI 0x46: imm 2'b10 sign-extends to 0xFE
    issue(8'h46, 8'h05, 8'h00);
    tick();
    check("addi_neg2", bus.regwritedata, 8'h03);
    tick();

    // LW 0xA1: mem[r2 + 1], ack in the second LOAD cycle
    issue(8'hA1, 8'h40, 8'h00);
    check("lw_rr1", bus.read_register1, 2);
    check("lw_exec_req", bus.mem_req, 0);
    tick();
    check("lw_load1", {bus.mem_req, bus.mem_addr}, {1'b1, 8'h41});
    tick();
    check("lw_load2", {bus.mem_req, bus.mem_addr}, {1'b1, 8'h41});
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'hA5;
    tick();
    bus.mem_ack   = 1'b0;
    check("lw_wb", {bus.regwrite, bus.regdst, bus.done, bus.mem_req}, 4'b1010);
    check("lw_data", bus.regwritedata, 8'hA5);
    tick();
    check("lw_retire", bus.instr_ready, 1);

    // LW with no ack: err in the 15th LOAD cycle
    issue(8'h80, 8'h10, 8'h00);
    tick();
    bad = 1'b0;
    for (int i = 1; i < 15; i++) begin
      if (bus.err || bus.regwrite || !bus.mem_req) bad = 1'b1;
      tick();
    end
    check("tmo_early", bad, 0);
    check("tmo_err", {bus.err, bus.mem_req, bus.done}, 3'b110);
    tick();
    check("tmo_after", {bus.instr_ready, bus.err, bus.regwrite}, 3'b100);

    // Ack in the expiring cycle counts as an ack
    issue(8'h80, 8'h20, 8'h00);
    tick();
    for (int i = 1; i < 15; i++) tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'h3C;
    #1;
    check("tmo_ack_noerr", {bus.err, bus.mem_req}, 2'b01);
    tick();
    bus.mem_ack = 1'b0;
    check("tmo_ack_wb", {bus.regwrite, bus.regwritedata}, {1'b1, 8'h3C});
    tick();

    // mem_ack while idle is ignored
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("idle_ack", {bus.busy, bus.regwrite, bus.instr_ready}, 3'b001);

    // NOP retires from EXEC without writing
    issue(8'hC0, 8'h00, 8'h00);
    check("nop_exec", {bus.done, bus.regwrite}, 2'b10);
    tick();
    check("nop_idle", {bus.instr_ready, bus.done}, 2'b10);

    // Reset during LOAD drops the load
    issue(8'h80, 8'h00, 8'h00);
    tick();
    check("rl_load", bus.mem_req, 1);
    rst = 1'b1;
    #1;
    check("rl_async", {bus.mem_req, bus.instr_ready, bus.busy}, 3'b010);
    tick();
    rst = 1'b0;
    tick();
    check("rl_quiet", {bus.regwrite, bus.done, bus.err}, 0);

    // ADD 0x7F + 0x01 -> 0x80 (signed overflow)
    issue(8'h1B, 8'h7F, 8'h01);
    tick();
    check("ovfadd_data", {bus.regwrite, bus.regwritedata}, {1'b1, 8'h80});
`ifdef SEQ_OVERFLOW_FLAG_EN
    check("ovf_set", ovf, 1);
`endif
    tick();
    issue(8'hC0, 8'h00, 8'h00);
    tick();
`ifdef SEQ_OVERFLOW_FLAG_EN
    check("ovf_hold_nop", ovf, 1);
`endif
    issue(8'h1B, 8'h01, 8'h01);
    tick();
    check("add2_data", bus.regwritedata, 8'h02);
`ifdef SEQ_OVERFLOW_FLAG_EN
    check("ovf_clr", ovf, 0);
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
